// File: rtl/tx_share_arbiter.sv
// tx_share_arbiter: round-robin sharing of one dav_/rfd transmitter port between producers A and B.
module tx_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_a,
  input  logic             dav_a_,
  output logic             rfd_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             dav_b_,
  output logic             rfd_b,
  output logic [WIDTH-1:0] data,
  output logic             dav_,
  input  logic             rfd,
  output logic             grant,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  typedef enum logic [1:0] {IDLE, RELEASE, OFFER, DRAIN} state_t;
  state_t state_q;
  logic   ptr_q;
  logic   sel_d;
  // a lone requester wins outright; contention is settled by the pointer
  always_comb sel_d = dav_a_ ? 1'b1 : (dav_b_ ? 1'b0 : ptr_q);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      rfd_a   <= 1'b1;
      rfd_b   <= 1'b1;
      dav_    <= 1'b1;
      data    <= '0;
      grant   <= 1'b0;
      busy    <= 1'b0;
      cnt_a   <= '0;
      cnt_b   <= '0;
    end else begin
      case (state_q)
        IDLE: if (!(dav_a_ && dav_b_)) begin
          data    <= sel_d ? data_b : data_a;
          grant   <= sel_d;
          rfd_a   <= sel_d;
          rfd_b   <= !sel_d;
          busy    <= 1'b1;
          state_q <= RELEASE;
        end
        RELEASE: if (grant ? dav_b_ : dav_a_) begin
          rfd_a   <= 1'b1;
          rfd_b   <= 1'b1;
          dav_    <= 1'b0;
          state_q <= OFFER;
        end
        OFFER: if (!rfd) begin
          dav_    <= 1'b1;
          state_q <= DRAIN;
        end
        DRAIN: if (rfd) begin
          ptr_q   <= ~grant;
          if (grant) cnt_b <= cnt_b + 1'b1;
          else cnt_a <= cnt_a + 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_share_arbiter.sv
// tb_tx_share_arbiter: transaction-level reference model of the A/B round-robin share, random and directed rounds.
module tb_tx_share_arbiter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_a = '0, data_b = '0, data;
  logic       dav_a_ = 1'b1, dav_b_ = 1'b1, rfd = 1'b1;
  logic       rfd_a, rfd_b, dav_, grant, busy;
  logic [7:0] cnt_a, cnt_b;
  int         errs = 0, checks = 0;
  bit         pa, pb, ptr;
  logic [7:0] ca, cb;

  tx_share_arbiter dut (
    .clock(clock), .reset(reset),
    .data_a(data_a), .dav_a_(dav_a_), .rfd_a(rfd_a),
    .data_b(data_b), .dav_b_(dav_b_), .rfd_b(rfd_b),
    .data(data), .dav_(dav_), .rfd(rfd),
    .grant(grant), .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  endtask

  // One byte through the share: optional new requests, then the winner's full handshake.
  task automatic round(input bit na, input bit nb, input logic [7:0] va, input logic [7:0] vb,
                       input int rel, input int d1, input int d2, input bit early);
    bit w;
    int n;
    logic [7:0] bw;
    if (na && !pa) begin pa = 1; data_a = va; dav_a_ = 0; end
    if (nb && !pb) begin pb = 1; data_b = vb; dav_b_ = 0; end
    if (!pa && !pb) return;
    w  = (pa && pb) ? ptr : pb;
    bw = w ? data_b : data_a;
    n  = 0;
    do begin @(negedge clock); n++; end while ((w ? rfd_b : rfd_a) && n < 4);
    chk("grant_wait", w ? rfd_b : rfd_a, 0);
    if (w ? rfd_b : rfd_a) finish_run();
    chk("grant", grant, w);
    chk("busy_on", busy, 1);
    chk("data_grant", data, bw);
    chk("other_rfd", w ? rfd_a : rfd_b, 1);
    chk("dav_idle", dav_, 1);
    repeat (rel) begin @(negedge clock); chk("release_hold", dav_, 1); end
    if (w) begin dav_b_ = 1; pb = 0; data_b = 8'($urandom); end
    else begin dav_a_ = 1; pa = 0; data_a = 8'($urandom); end
    if (early) rfd = 0;
    @(negedge clock);
    chk("offer", dav_, 0);
    chk("rfd_back", w ? rfd_b : rfd_a, 1);
    if (!early) begin
      repeat (d1) begin @(negedge clock); chk("offer_hold", dav_, 0); end
      rfd = 0;
    end
    chk("data_cap", data, bw);
    @(negedge clock);
    chk("drain", dav_, 1);
    chk("busy_drain", busy, 1);
    repeat (d2) begin @(negedge clock); chk("drain_hold", busy, 1); end
    rfd = 1;
    @(negedge clock);
    chk("idle", busy, 0);
    ptr = ~w;
    if (w) cb++; else ca++;
    chk("cnt_a", cnt_a, ca);
    chk("cnt_b", cnt_b, cb);
  endtask

  initial begin
    pa = 0; pb = 0; ptr = 0; ca = 0; cb = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_rfd_a", rfd_a, 1);
    chk("rst_rfd_b", rfd_b, 1);
    chk("rst_dav", dav_, 1);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", {cnt_a, cnt_b}, 0);
    round(1, 0, 8'h3C, 8'h00, 0, 0, 0, 0);
    data_b = 8'h77; dav_b_ = 0;
    @(negedge clock);
    chk("mid_grant", grant, 1);
    dav_b_ = 1;
    @(negedge clock);
    chk("mid_offer", dav_, 0);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("mr_dav", dav_, 1);
    chk("mr_rfd", {rfd_a, rfd_b}, 2'b11);
    chk("mr_busy", busy, 0);
    chk("mr_cnt", {cnt_a, cnt_b}, 0);
    chk("mr_grant", grant, 0);
    ptr = 0; ca = 0; cb = 0;
    round(1, 1, 8'h11, 8'h22, 0, 0, 0, 0);
    round(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    round(1, 0, 8'hA5, 8'h00, 0, 2, 2, 0);
    for (int i = 0; i < 6; i++) round(1, 1, 8'($urandom), 8'($urandom), 0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) round(0, 1, 8'h00, 8'(i), 0, 0, 1, 0);
    round(1, 0, 8'h5A, 8'h00, 5, 0, 0, 0);
    round(0, 1, 8'h00, 8'hC3, 2, 0, 1, 1);
    for (int i = 0; i < 256; i++) round(1, 0, 8'(i), 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      round($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 5) == 0);
    while (pa || pb) round(0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    finish_run();
  end
endmodule
